// File: rtl/hilo_muldiv_sequencer_pkg.sv
// Shared opcodes, FSM encoding and sign helpers for the HI/LO multiply/divide sequencer.
package hilo_muldiv_sequencer_pkg;

    localparam logic [3:0] ALU_MULT = 4'b1101;
    localparam logic [3:0] ALU_DIV  = 4'b1011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [31:0] mag32(input logic [31:0] v);
        return v[31] ? -v : v;
    endfunction

    function automatic logic [31:0] neg_if32(input logic [31:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

endpackage

// File: rtl/hilo_muldiv_sequencer_if.sv
// Request/result bundle between the decode stage and the multiply/divide sequencer.
interface hilo_muldiv_sequencer_if #(parameter int WIDTH = 32);

    logic             start;
    logic [3:0]       ALU_control;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             hilo_read;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;
    logic             hilo_we;
    logic             busy;
    logic             stall;

    modport master (
        output start, ALU_control, A, B, hilo_read,
        input  Hi, Lo, hilo_we, busy, stall
    );

    modport slave (
        input  start, ALU_control, A, B, hilo_read,
        output Hi, Lo, hilo_we, busy, stall
    );

endinterface

// File: rtl/hilo_muldiv_sequencer_step.sv
// One-bit-per-cycle unsigned datapath: shift-add multiply or restoring shift-subtract divide.
// The 2*WIDTH accumulator holds {product} for multiply and {remainder, quotient} for divide.
module muldiv_step_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a_mag,
    input  logic [WIDTH-1:0] b_mag,
    output logic [WIDTH-1:0] acc_hi,
    output logic [WIDTH-1:0] acc_lo
);

    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_trial;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_next;

    // Multiply keeps the multiplier in the low half and shifts it out LSB first.
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_next = {mul_sum, acc[WIDTH-1:1]};
    end

    // Remainder stays below the divisor, so the shifted trial always fits in WIDTH+1 bits.
    always_comb begin
        div_trial = acc[2*WIDTH-1:WIDTH-1];
        div_diff  = div_trial - {1'b0, opnd};
        div_ge    = ~div_diff[WIDTH];
        div_next  = {(div_ge ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0]),
                     acc[WIDTH-2:0], div_ge};
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            acc  <= '0;
            opnd <= '0;
        end else if (load) begin
            acc  <= {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
            opnd <= is_div ? b_mag : a_mag;
        end else if (step) begin
            acc  <= is_div ? div_next : mul_next;
        end
    end

    assign acc_hi = acc[2*WIDTH-1:WIDTH];
    assign acc_lo = acc[WIDTH-1:0];

endmodule

// File: rtl/hilo_muldiv_sequencer.sv
// Sequencer for signed mult/div into HI/LO: sign-magnitude operands, 32-cycle iteration,
// sign fixup and a single write strobe.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start with a mult/div opcode; Hi/Lo hold last result
// RUN   | one datapath iteration per cycle, counter 0..31
// DONE  | sign fixup, Hi/Lo load and hilo_we strobe on the next edge
module hilo_muldiv_sequencer
    import hilo_muldiv_sequencer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic                    CLK,
    input logic                    RESET,
    hilo_muldiv_sequencer_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;

    logic             op_valid;
    logic             accept;
    logic             b_zero;
    logic             busy;
    logic             step_en;
    logic             done_en;

    logic             op_div_q;
    logic             quot_neg_q;
    logic             rem_neg_q;
    logic             dz_q;
    logic             step_is_div;

    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             we_q;

    assign op_valid = (bus.ALU_control == ALU_MULT) || (bus.ALU_control == ALU_DIV);
    assign accept   = (state == IDLE) && bus.start && op_valid;
    assign b_zero   = (bus.B == '0);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= IDLE;
        else       state <= state_nx;
    end

    // Divide by zero has nothing to iterate, so it bypasses RUN entirely.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept)
                      state_nx = ((bus.ALU_control == ALU_DIV) && b_zero) ? DONE : RUN;
            RUN:  if (cnt == CNT_LAST) state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy    = 1'b0;
        step_en = 1'b0;
        done_en = 1'b0;
        case (state)
            RUN: begin
                busy    = 1'b1;
                step_en = 1'b1;
            end
            DONE: begin
                busy    = 1'b1;
                done_en = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)         cnt <= '0;
        else if (step_en)  cnt <= cnt + 1'b1;
        else               cnt <= '0;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            op_div_q   <= 1'b0;
            quot_neg_q <= 1'b0;
            rem_neg_q  <= 1'b0;
            dz_q       <= 1'b0;
        end else if (accept) begin
            op_div_q   <= (bus.ALU_control == ALU_DIV);
            quot_neg_q <= bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
            rem_neg_q  <= bus.A[WIDTH-1];
            dz_q       <= (bus.ALU_control == ALU_DIV) && b_zero;
        end
    end

    // On the accepting edge the op register is not yet loaded, so steer from the opcode.
    assign step_is_div = accept ? (bus.ALU_control == ALU_DIV) : op_div_q;

    muldiv_step_unit #(.WIDTH(WIDTH)) u_step (
        .CLK    (CLK),
        .RESET  (RESET),
        .load   (accept),
        .step   (step_en),
        .is_div (step_is_div),
        .a_mag  (mag32(bus.A)),
        .b_mag  (mag32(bus.B)),
        .acc_hi (acc_hi),
        .acc_lo (acc_lo)
    );

    // For divide by zero the untouched low half still holds |A|; restoring its sign gives A back.
    always_comb begin
        prod   = {acc_hi, acc_lo};
        fix_hi = '0;
        fix_lo = '0;
        if (op_div_q) begin
            if (dz_q) begin
                fix_hi = neg_if32(acc_lo, rem_neg_q);
                fix_lo = '1;
            end else begin
                fix_hi = neg_if32(acc_hi, rem_neg_q);
                fix_lo = neg_if32(acc_lo, quot_neg_q);
            end
        end else begin
            if (quot_neg_q) prod = -prod;
            fix_hi = prod[2*WIDTH-1:WIDTH];
            fix_lo = prod[WIDTH-1:0];
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            hi_q <= '0;
            lo_q <= '0;
            we_q <= 1'b0;
        end else begin
            we_q <= done_en;
            if (done_en) begin
                hi_q <= fix_hi;
                lo_q <= fix_lo;
            end
        end
    end

    assign bus.Hi      = hi_q;
    assign bus.Lo      = lo_q;
    assign bus.hilo_we = we_q;
    assign bus.busy    = busy;
    assign bus.stall   = (bus.hilo_read & busy) | (bus.start & busy);

endmodule
